// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MEM stage of a 5-stage pipeline with a variable-latency data-memory handshake
//   and the MEM/WB pipeline register.
//   An aligned load or store presented at EX/MEM raises mem_stall combinationally.
//   The request is then registered onto dmem_* and held until dmem_ack arrives or
//   the BUSY timeout expires. Misaligned and read+write-conflict accesses fault
//   immediately without touching memory.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   *_mem                 EX/MEM register contents (control, address/ALU result, store
//                         data, destination register, PC+4)
//   dmem_req/we/addr/wdata  registered data-memory request, held constant while BUSY
//   dmem_ack, dmem_rdata  one-cycle completion pulse and load data
//   mem_stall             freezes PC, IF/ID, ID/EX and EX/MEM while high
//   *_wb                  MEM/WB register contents
//   mem_fault             one-cycle pulse per faulted access
//   fault_cause           01 misaligned, 10 read+write, 11 timeout; held until next fault
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_write_mem,
    input  logic        mem_read_mem,
    input  logic        mem_write_mem,
    input  logic [1:0]  mem_to_reg_mem,
    input  logic [31:0] alu_result_mem,
    input  logic [31:0] read_data2_mem,
    input  logic [4:0]  write_reg_mem,
    input  logic [31:0] pc_plus_4_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        reg_write_wb,
    output logic [1:0]  mem_to_reg_wb,
    output logic [4:0]  write_reg_wb,
    output logic [31:0] alu_result_wb,
    output logic [31:0] mem_data_wb,
    output logic [31:0] pc_plus_4_wb,
    output logic        mem_fault,
    output logic [1:0]  fault_cause
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    // Counter value on the last BUSY cycle before the timeout fires.
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYCLES);

    localparam logic [1:0] CauseMisaligned = 2'b01;
    localparam logic [1:0] CauseConflict   = 2'b10;
    localparam logic [1:0] CauseTimeout    = 2'b11;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        fault_q, fault_d;
    logic [1:0]  cause_q, cause_d;

    logic        wb_rw_q, wb_rw_d;
    logic [1:0]  wb_mtr_q, wb_mtr_d;
    logic [4:0]  wb_reg_q, wb_reg_d;
    logic [31:0] wb_alu_q, wb_alu_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [31:0] wb_pc_q, wb_pc_d;

    logic access_valid;
    logic aligned;
    logic conflict;
    logic stall;

    assign access_valid = mem_read_mem | mem_write_mem;
    assign aligned      = (alu_result_mem[1:0] == 2'b00);
    assign conflict     = mem_read_mem & mem_write_mem;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        fault_d   = 1'b0;
        cause_d   = cause_q;
        stall     = 1'b0;
        // MEM/WB takes a bubble unless an instruction retires from MEM this cycle.
        wb_rw_d   = 1'b0;
        wb_mtr_d  = 2'b00;
        wb_reg_d  = 5'd0;
        wb_alu_d  = 32'd0;
        wb_data_d = 32'd0;
        wb_pc_d   = 32'd0;

        unique case (state_q)
            StIdle: begin
                if (access_valid) begin
                    if (!aligned) begin
                        fault_d = 1'b1;
                        cause_d = CauseMisaligned;
                    end else if (conflict) begin
                        fault_d = 1'b1;
                        cause_d = CauseConflict;
                    end else begin
                        stall   = 1'b1;
                        req_d   = 1'b1;
                        we_d    = mem_write_mem;
                        addr_d  = alu_result_mem;
                        wdata_d = read_data2_mem;
                        cnt_d   = '0;
                        state_d = StBusy;
                    end
                end else begin
                    wb_rw_d  = reg_write_mem;
                    wb_mtr_d = mem_to_reg_mem;
                    wb_reg_d = write_reg_mem;
                    wb_alu_d = alu_result_mem;
                    wb_pc_d  = pc_plus_4_mem;
                end
            end
            StBusy: begin
                if (dmem_ack) begin
                    // EX/MEM was frozen while BUSY, so its fields still describe this access.
                    req_d     = 1'b0;
                    wb_rw_d   = reg_write_mem;
                    wb_mtr_d  = mem_to_reg_mem;
                    wb_reg_d  = write_reg_mem;
                    wb_alu_d  = alu_result_mem;
                    wb_data_d = mem_read_mem ? dmem_rdata : 32'd0;
                    wb_pc_d   = pc_plus_4_mem;
                    state_d   = StIdle;
                end else if (cnt_q >= CntLast) begin
                    // Release the pipeline this cycle so the faulted access leaves EX/MEM.
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                    cause_d = CauseTimeout;
                    state_d = StIdle;
                end else begin
                    stall = 1'b1;
                    if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            fault_q   <= 1'b0;
            cause_q   <= 2'b00;
            wb_rw_q   <= 1'b0;
            wb_mtr_q  <= 2'b00;
            wb_reg_q  <= 5'd0;
            wb_alu_q  <= 32'd0;
            wb_data_q <= 32'd0;
            wb_pc_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            fault_q   <= fault_d;
            cause_q   <= cause_d;
            wb_rw_q   <= wb_rw_d;
            wb_mtr_q  <= wb_mtr_d;
            wb_reg_q  <= wb_reg_d;
            wb_alu_q  <= wb_alu_d;
            wb_data_q <= wb_data_d;
            wb_pc_q   <= wb_pc_d;
        end
    end

    // Stall is forced low while reset is held so every output reads 0 during reset.
    assign mem_stall     = stall & ~reset;
    assign dmem_req      = req_q;
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_wdata    = wdata_q;
    assign mem_fault     = fault_q;
    assign fault_cause   = cause_q;
    assign reg_write_wb  = wb_rw_q;
    assign mem_to_reg_wb = wb_mtr_q;
    assign write_reg_wb  = wb_reg_q;
    assign alu_result_wb = wb_alu_q;
    assign mem_data_wb   = wb_data_q;
    assign pc_plus_4_wb  = wb_pc_q;

endmodule

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
module tb_mem_access_unit;

    localparam int TO = 16;

    logic        clk;
    logic        reset;
    logic        reg_write_mem, mem_read_mem, mem_write_mem;
    logic [1:0]  mem_to_reg_mem;
    logic [31:0] alu_result_mem, read_data2_mem, pc_plus_4_mem;
    logic [4:0]  write_reg_mem;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        mem_stall;
    logic        reg_write_wb;
    logic [1:0]  mem_to_reg_wb;
    logic [4:0]  write_reg_wb;
    logic [31:0] alu_result_wb, mem_data_wb, pc_plus_4_wb;
    logic        mem_fault;
    logic [1:0]  fault_cause;

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .reg_write_mem(reg_write_mem), .mem_read_mem(mem_read_mem),
        .mem_write_mem(mem_write_mem), .mem_to_reg_mem(mem_to_reg_mem),
        .alu_result_mem(alu_result_mem), .read_data2_mem(read_data2_mem),
        .write_reg_mem(write_reg_mem), .pc_plus_4_mem(pc_plus_4_mem),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .reg_write_wb(reg_write_wb), .mem_to_reg_wb(mem_to_reg_wb),
        .write_reg_wb(write_reg_wb), .alu_result_wb(alu_result_wb),
        .mem_data_wb(mem_data_wb), .pc_plus_4_wb(pc_plus_4_wb),
        .mem_fault(mem_fault), .fault_cause(fault_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw;
        logic        rd;
        logic        wr;
        logic [1:0]  mtr;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  wreg;
        logic [31:0] pc;
    } instr_t;

    // One retired MEM/WB entry: rw, mem_to_reg, dest, alu, mem data, pc+4.
    typedef struct packed {
        logic        rw;
        logic [1:0]  mtr;
        logic [4:0]  wreg;
        logic [31:0] alu;
        logic [31:0] data;
        logic [31:0] pc;
    } wb_t;

    int total = 0;
    int bad   = 0;

    instr_t     prog_q[$];
    wb_t        got_q[$], exp_q[$];
    logic [1:0] got_f[$], exp_f[$];
    int         stall_cnt, req_cnt, we_cnt, busy_changed, exp_stall, exp_req;
    logic [31:0] addr0, wdata0;
    bit          force_en;
    logic [31:0] force_val;

    // Memory contents as seen by the bench: a fixed hash of the address.
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (force_en) return force_val;
        return (a * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic instr_t mk(input logic rw, input logic rd, input logic wr,
                                  input logic [1:0] mtr, input logic [31:0] alu,
                                  input logic [31:0] sd, input logic [4:0] wreg,
                                  input logic [31:0] pc);
        instr_t i;
        i.rw = rw; i.rd = rd; i.wr = wr; i.mtr = mtr; i.alu = alu;
        i.sd = sd; i.wreg = wreg; i.pc = pc;
        return i;
    endfunction

    function automatic instr_t rand_instr(input logic [31:0] pc);
        int k;
        logic [4:0] r;
        logic [31:0] a;
        k = $urandom_range(0, 9);
        r = 5'($urandom_range(1, 31));
        a = $urandom & 32'h0000_FFFC;
        if (k < 3)       return mk(1'b1, 1'b0, 1'b0, (k == 2) ? 2'b10 : 2'b00, $urandom,
                                   $urandom, r, pc);
        else if (k < 6)  return mk(1'b1, 1'b1, 1'b0, 2'b01, a, $urandom, r, pc);
        else if (k < 8)  return mk(1'b0, 1'b0, 1'b1, 2'b00, a, $urandom, r, pc);
        else if (k == 8) return mk(1'b1, 1'b1, 1'b0, 2'b01, a | 32'($urandom_range(1, 3)),
                                   $urandom, r, pc);
        else             return mk(1'b1, 1'b1, 1'b1, 2'b01, a, $urandom, r, pc);
    endfunction

    task automatic present(input instr_t i);
        reg_write_mem  = i.rw;
        mem_read_mem   = i.rd;
        mem_write_mem  = i.wr;
        mem_to_reg_mem = i.mtr;
        alu_result_mem = i.alu;
        read_data2_mem = i.sd;
        write_reg_mem  = i.wreg;
        pc_plus_4_mem  = i.pc;
    endtask

    // Per-instruction outcome of prog_q for a memory that acks on BUSY cycle 'lat'
    // (0 = never).
    task automatic build_model(input int lat);
        instr_t i;
        wb_t    w;
        exp_q.delete(); exp_f.delete();
        exp_stall = 0; exp_req = 0;
        foreach (prog_q[k]) begin
            i = prog_q[k];
            if (!(i.rd || i.wr)) begin
                w = {i.rw, i.mtr, i.wreg, i.alu, 32'h0, i.pc};
                exp_q.push_back(w);
            end else if (i.alu[1:0] != 2'b00) begin
                exp_f.push_back(2'b01);
            end else if (i.rd && i.wr) begin
                exp_f.push_back(2'b10);
            end else if (lat >= 1 && lat <= TO) begin
                exp_stall += lat;
                exp_req   += lat;
                w = {i.rw, i.mtr, i.wreg, i.alu, i.rd ? mem_val(i.alu) : 32'h0, i.pc};
                exp_q.push_back(w);
            end else begin
                exp_stall += TO;
                exp_req   += TO;
                exp_f.push_back(2'b11);
            end
        end
    endtask

    // Plays the upstream pipeline and the data memory for prog_q, recording what
    // the DUT does. Entered and left at posedge+1.
    task automatic run_seq(input int lat, input bit stray);
        int   idx, busy, cyc;
        logic stalled;
        wb_t  w;
        idx = 0; busy = 0; cyc = 0;
        got_q.delete(); got_f.delete();
        stall_cnt = 0; req_cnt = 0; we_cnt = 0; busy_changed = 0;
        while ((idx < prog_q.size() || dmem_req === 1'b1) && cyc < 1000) begin
            if (idx < prog_q.size()) present(prog_q[idx]);
            else present('0);
            if (dmem_req === 1'b1) begin
                busy++;
                if (busy == 1) begin
                    addr0 = dmem_addr; wdata0 = dmem_wdata;
                end else if (dmem_addr !== addr0 || dmem_wdata !== wdata0) begin
                    busy_changed++;
                end
                if (dmem_we === 1'b1) we_cnt++;
                req_cnt++;
                dmem_ack   = (lat != 0 && busy == lat);
                dmem_rdata = dmem_ack ? mem_val(dmem_addr) : $urandom;
            end else begin
                busy = 0;
                dmem_ack   = stray && ($urandom_range(0, 3) == 0);
                dmem_rdata = $urandom;
            end
            #1;
            stalled = mem_stall;
            if (stalled === 1'b1) stall_cnt++;
            @(posedge clk);
            #1;
            if (stalled !== 1'b1) idx++;
            if (pc_plus_4_wb != 32'h0) begin
                w = {reg_write_wb, mem_to_reg_wb, write_reg_wb, alu_result_wb,
                     mem_data_wb, pc_plus_4_wb};
                got_q.push_back(w);
            end
            if (mem_fault === 1'b1) got_f.push_back(fault_cause);
            cyc++;
        end
        present('0);
        dmem_ack = 1'b0;
        total++;
        if (cyc >= 1000) begin
            bad++;
            $display("FAIL seq_bound: sequence still running after %0d cycles (limit 1000)", cyc);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        present('0);
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        force_en = 1'b0; force_val = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== 66'h0) begin
            bad++;
            $display("FAIL reset_dmem: got req=%b we=%b addr=%h wdata=%h want all 0",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata);
        end
        total++;
        if ({mem_fault, fault_cause, mem_stall} !== 4'h0) begin
            bad++;
            $display("FAIL reset_fault: got fault=%b cause=%b stall=%b want 0",
                     mem_fault, fault_cause, mem_stall);
        end
        total++;
        if ({reg_write_wb, mem_to_reg_wb, write_reg_wb, alu_result_wb, mem_data_wb,
             pc_plus_4_wb} !== 104'h0) begin
            bad++;
            $display("FAIL reset_wb: got rw=%b pc=%h alu=%h want all 0", reg_write_wb,
                     pc_plus_4_wb, alu_result_wb);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (mem_stall !== 1'b0) begin
            bad++;
            $display("FAIL idle_stall: got %b want 0", mem_stall);
        end
        present(mk(1'b1, 1'b1, 1'b0, 2'b01, 32'h40, 32'h0, 5'd3, 32'h4));
        #1;
        total++;
        if (mem_stall !== 1'b1) begin
            bad++;
            $display("FAIL access_stall: got %b want 1", mem_stall);
        end
        present('0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_zero_wait;
        force_en = 1'b1; force_val = 32'hDEADBEEF;
        prog_q.delete();
        prog_q.push_back(mk(1'b1, 1'b1, 1'b0, 2'b01, 32'h100, 32'h0, 5'd9, 32'h2004));
        run_seq(1, 1'b0);
        force_en = 1'b0;
        total++;
        if (stall_cnt != 1) begin
            bad++;
            $display("FAIL lw_stall_cycles: got %0d want 1", stall_cnt);
        end
        total++;
        if (got_q.size() != 1) begin
            bad++;
            $display("FAIL lw_entries: got %0d want 1", got_q.size());
        end else begin
            total++;
            if (got_q[0].data !== 32'hDEADBEEF || got_q[0].rw !== 1'b1 ||
                got_q[0].wreg !== 5'd9) begin
                bad++;
                $display("FAIL lw_wb: got data=%h rw=%b rd=%0d want DEADBEEF 1 9",
                         got_q[0].data, got_q[0].rw, got_q[0].wreg);
            end
        end
    endtask

    task automatic test_store_wait;
        prog_q.delete();
        prog_q.push_back(mk(1'b0, 1'b0, 1'b1, 2'b00, 32'h204, 32'h12345678, 5'd4, 32'h3008));
        run_seq(3, 1'b0);
        total++;
        if (req_cnt != 3 || we_cnt != 3) begin
            bad++;
            $display("FAIL sw_req: got req=%0d we=%0d cycles want 3 3", req_cnt, we_cnt);
        end
        total++;
        if (addr0 !== 32'h204 || wdata0 !== 32'h12345678 || busy_changed != 0) begin
            bad++;
            $display("FAIL sw_bus: got addr=%h wdata=%h changes=%0d want 204 12345678 0",
                     addr0, wdata0, busy_changed);
        end
        total++;
        if (stall_cnt != 3) begin
            bad++;
            $display("FAIL sw_stall_cycles: got %0d want 3", stall_cnt);
        end
        total++;
        if (got_q.size() != 1 || got_q[0].rw !== 1'b0 || got_q[0].data !== 32'h0) begin
            bad++;
            $display("FAIL sw_wb: got %0d entries want 1 with rw=0 data=0", got_q.size());
        end
    endtask

    task automatic test_faults;
        prog_q.delete();
        prog_q.push_back(mk(1'b1, 1'b1, 1'b0, 2'b01, 32'h102, 32'h0, 5'd5, 32'h4000));
        run_seq(1, 1'b0);
        total++;
        if (req_cnt != 0 || stall_cnt != 0 || got_q.size() != 0) begin
            bad++;
            $display("FAIL misaligned_quiet: got req=%0d stall=%0d wb=%0d want 0 0 0",
                     req_cnt, stall_cnt, got_q.size());
        end
        total++;
        if (got_f.size() != 1 || got_f[0] !== 2'b01) begin
            bad++;
            $display("FAIL misaligned_fault: got %0d pulses want 1 with cause 01",
                     got_f.size());
        end
        // Read and write together, but misaligned: misalignment wins.
        prog_q.delete();
        prog_q.push_back(mk(1'b1, 1'b1, 1'b1, 2'b01, 32'h201, 32'h0, 5'd5, 32'h4004));
        prog_q.push_back(mk(1'b1, 1'b1, 1'b1, 2'b01, 32'h200, 32'h0, 5'd6, 32'h4008));
        run_seq(1, 1'b0);
        total++;
        if (got_f.size() != 2 || got_f[0] !== 2'b01 || got_f[1] !== 2'b10 || req_cnt != 0) begin
            bad++;
            $display("FAIL conflict_fault: got %0d pulses req=%0d want causes 01,10 req 0",
                     got_f.size(), req_cnt);
        end
        total++;
        if (fault_cause !== 2'b10) begin
            bad++;
            $display("FAIL cause_held: got %b want 10", fault_cause);
        end
    endtask

    task automatic test_timeout;
        logic [31:0] q;
        prog_q.delete();
        prog_q.push_back(mk(1'b1, 1'b1, 1'b0, 2'b01, 32'h300, 32'h0, 5'd7, 32'h5000));
        prog_q.push_back(mk(1'b1, 1'b0, 1'b0, 2'b00, 32'hCAFE, 32'h0, 5'd8, 32'h5004));
        build_model(0);
        run_seq(0, 1'b1);
        total++;
        if (req_cnt != exp_req || stall_cnt != exp_stall) begin
            bad++;
            $display("FAIL timeout_cycles: got req=%0d stall=%0d want %0d %0d",
                     req_cnt, stall_cnt, exp_req, exp_stall);
        end
        total++;
        if (got_f.size() != 1 || got_f[0] !== 2'b11) begin
            bad++;
            $display("FAIL timeout_fault: got %0d pulses want 1 with cause 11", got_f.size());
        end
        total++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            bad++;
            $display("FAIL timeout_wb: got %0d entries want only the ADD", got_q.size());
        end
        // A late ack for the abandoned load must change nothing.
        dmem_ack = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        q = pc_plus_4_wb;
        @(posedge clk);
        #1;
        total++;
        if (dmem_req !== 1'b0 || mem_fault !== 1'b0 || q !== 32'h0 || mem_stall !== 1'b0 ||
            fault_cause !== 2'b11) begin
            bad++;
            $display("FAIL late_ack: got req=%b fault=%b wbpc=%h cause=%b want 0 0 0 11",
                     dmem_req, mem_fault, q, fault_cause);
        end
    endtask

    task automatic test_back_to_back;
        prog_q.delete();
        prog_q.push_back(mk(1'b1, 1'b0, 1'b0, 2'b00, 32'h1111, 32'h0, 5'd1, 32'h6000));
        prog_q.push_back(mk(1'b1, 1'b1, 1'b0, 2'b01, 32'h480, 32'h0, 5'd2, 32'h6004));
        prog_q.push_back(mk(1'b1, 1'b0, 1'b0, 2'b00, 32'h3333, 32'h0, 5'd3, 32'h6008));
        build_model(2);
        run_seq(2, 1'b0);
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL b2b_count: got %0d entries want %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[k]) begin
                total++;
                if (got_q[k] !== exp_q[k]) begin
                    bad++;
                    $display("FAIL b2b_entry%0d: got %h want %h", k, got_q[k], exp_q[k]);
                end
            end
        end
        total++;
        if (stall_cnt != exp_stall) begin
            bad++;
            $display("FAIL b2b_stall: got %0d want %0d", stall_cnt, exp_stall);
        end
    endtask

    task automatic test_random;
        int lats[7] = '{1, 2, 3, 5, 0, 17, 16};
        int nerr;
        for (int s = 0; s < 7; s++) begin
            prog_q.delete();
            for (int n = 0; n < 10; n++) prog_q.push_back(rand_instr(32'h8000 + 32'(s * 64 + n * 4)));
            build_model(lats[s]);
            run_seq(lats[s], 1'b1);
            nerr = 0;
            if (got_q.size() != exp_q.size()) nerr++;
            else foreach (exp_q[k]) if (got_q[k] !== exp_q[k]) nerr++;
            total++;
            if (nerr != 0) begin
                bad++;
                $display("FAIL rand%0d_wb: got %0d entries (%0d wrong) want %0d", s,
                         got_q.size(), nerr, exp_q.size());
            end
            total++;
            if (got_f != exp_f) begin
                bad++;
                $display("FAIL rand%0d_faults: got %0d pulses want %0d", s, got_f.size(),
                         exp_f.size());
            end
            total++;
            if (stall_cnt != exp_stall || req_cnt != exp_req) begin
                bad++;
                $display("FAIL rand%0d_cycles: got stall=%0d req=%0d want %0d %0d", s,
                         stall_cnt, req_cnt, exp_stall, exp_req);
            end
        end
    endtask

    task automatic test_reset_mid_busy;
        present(mk(1'b1, 1'b1, 1'b0, 2'b01, 32'h700, 32'h55, 5'd10, 32'h9000));
        dmem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (dmem_req !== 1'b1 || mem_stall !== 1'b1) begin
            bad++;
            $display("FAIL busy_before_reset: got req=%b stall=%b want 1 1", dmem_req, mem_stall);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_fault, fault_cause, mem_stall,
             reg_write_wb, mem_to_reg_wb, write_reg_wb, alu_result_wb, mem_data_wb,
             pc_plus_4_wb} !== 174'h0) begin
            bad++;
            $display("FAIL reset_async: got req=%b addr=%h stall=%b cause=%b want all 0",
                     dmem_req, dmem_addr, mem_stall, fault_cause);
        end
        present('0);
        @(negedge clk);
        reset = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'h1234_0000;
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (dmem_req !== 1'b0 || mem_fault !== 1'b0 || fault_cause !== 2'b00 ||
            pc_plus_4_wb !== 32'h0) begin
            bad++;
            $display("FAIL reset_late_ack: got req=%b fault=%b cause=%b wbpc=%h want 0 0 00 0",
                     dmem_req, mem_fault, fault_cause, pc_plus_4_wb);
        end
    endtask

    initial begin
        test_reset();
        test_load_zero_wait();
        test_store_wait();
        test_faults();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
